// File: rtl/tri_pkg.sv
// Shared types and width helpers for the triangle rasteriser.
// Widths are derived per instance from W via the helper functions.
package tri_pkg;

    localparam int unsigned TRI_W = 11;

    function automatic int unsigned diff_w(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned edge_w(input int unsigned w);
        return 2 * w + 3;
    endfunction

    typedef logic [TRI_W-1:0]                 coord_t;
    typedef logic signed [2*TRI_W+2:0]        edge_t;

    typedef enum logic [2:0] {IDLE, SETUP, SCAN, DRAIN, DONE} state_t;

endpackage

// File: rtl/edge_fn.sv
// Signed edge function Eab(p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax),
// computed at full precision from unsigned W-bit coordinates.
module edge_fn
    import tri_pkg::*;
#(
    parameter int unsigned W = 11
) (
    input  logic [W-1:0]                 ax,
    input  logic [W-1:0]                 ay,
    input  logic [W-1:0]                 bx,
    input  logic [W-1:0]                 by,
    input  logic [W-1:0]                 px,
    input  logic [W-1:0]                 py,
    output logic signed [edge_w(W)-1:0]  e
);
    localparam int unsigned DIFF_W = diff_w(W);
    localparam int unsigned PROD_W = 2 * DIFF_W;

    logic [DIFF_W-1:0]        d_bax, d_pya, d_bay, d_pxa;
    logic signed [PROD_W-1:0] m1, m2;

    // A (W+1)-bit wrap of the unsigned difference is the exact two's-complement value.
    assign d_bax = {1'b0, bx} - {1'b0, ax};
    assign d_pya = {1'b0, py} - {1'b0, ay};
    assign d_bay = {1'b0, by} - {1'b0, ay};
    assign d_pxa = {1'b0, px} - {1'b0, ax};

    assign m1 = $signed({{DIFF_W{d_bax[DIFF_W-1]}}, d_bax}) *
                $signed({{DIFF_W{d_pya[DIFF_W-1]}}, d_pya});
    assign m2 = $signed({{DIFF_W{d_bay[DIFF_W-1]}}, d_bay}) *
                $signed({{DIFF_W{d_pxa[DIFF_W-1]}}, d_pxa});

    assign e = $signed({m1[PROD_W-1], m1}) - $signed({m2[PROD_W-1], m2});

endmodule

// File: rtl/tri_raster.sv
// Bounding-box scan rasteriser: one triangle per handshake, one candidate pixel
// per cycle, covered pixels streamed through a one-deep look-ahead for pix_last.
module tri_raster
    import tri_pkg::*;
#(
    parameter int unsigned W         = 11,
    parameter bit          INCLUSIVE = 1'b0,
    parameter bit          EMIT_ALL  = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tri_valid,
    output logic         tri_ready,
    input  logic [W-1:0] p1x,
    input  logic [W-1:0] p1y,
    input  logic [W-1:0] p2x,
    input  logic [W-1:0] p2y,
    input  logic [W-1:0] p3x,
    input  logic [W-1:0] p3y,
    output logic         pix_valid,
    input  logic         pix_ready,
    output logic [W-1:0] pix_x,
    output logic [W-1:0] pix_y,
    output logic         pix_inside,
    output logic         pix_last,
    output logic         busy,
    output logic         done
);
    localparam int unsigned EDGE_W = edge_w(W);

    state_t state, state_nx;

    logic [W-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic [W-1:0] xmin, xmax, ymin, ymax, x, y;
    logic [W-1:0] hold_x, hold_y;
    logic         hold_valid, hold_inside;
    logic signed [EDGE_W-1:0] e12, e23, e31, area;
    logic [2:0]   pos, neg;
    logic         covered, out_free, advance, load, scan_end;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    edge_fn #(.W(W)) u_e12  (.ax(v1x), .ay(v1y), .bx(v2x), .by(v2y), .px(x),   .py(y),   .e(e12));
    edge_fn #(.W(W)) u_e23  (.ax(v2x), .ay(v2y), .bx(v3x), .by(v3y), .px(x),   .py(y),   .e(e23));
    edge_fn #(.W(W)) u_e31  (.ax(v3x), .ay(v3y), .bx(v1x), .by(v1y), .px(x),   .py(y),   .e(e31));
    edge_fn #(.W(W)) u_area (.ax(v1x), .ay(v1y), .bx(v2x), .by(v2y), .px(v3x), .py(v3y), .e(area));

    always_comb begin
        neg = {e31[EDGE_W-1], e23[EDGE_W-1], e12[EDGE_W-1]};
        pos = ~neg & {(e31 != '0), (e23 != '0), (e12 != '0)};
        if (INCLUSIVE) covered = (&(~neg)) || (&(~pos));
        else           covered = (&pos) || (&neg);
    end

    assign out_free = !pix_valid || pix_ready;
    assign advance  = (state == SCAN) && out_free;
    assign load     = advance && (covered || EMIT_ALL);
    assign scan_end = (x == xmax) && (y == ymax);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        tri_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                tri_ready = 1'b1;
                busy      = 1'b0;
                if (tri_valid) state_nx = SETUP;
            end
            SETUP:   state_nx = (area == '0) ? DONE : SCAN;
            SCAN:    if (advance && scan_end) state_nx = DRAIN;
            DRAIN:   if (!hold_valid && out_free) state_nx = DONE;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_inside <= 1'b0;
            pix_last   <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            if (pix_valid && pix_ready) pix_valid <= 1'b0;
            if (state == IDLE && tri_valid) begin
                v1x <= p1x; v1y <= p1y;
                v2x <= p2x; v2y <= p2y;
                v3x <= p3x; v3y <= p3y;
            end
            if (state == SETUP) begin
                xmin       <= min3(v1x, v2x, v3x);
                xmax       <= max3(v1x, v2x, v3x);
                ymin       <= min3(v1y, v2y, v3y);
                ymax       <= max3(v1y, v2y, v3y);
                x          <= min3(v1x, v2x, v3x);
                y          <= min3(v1y, v2y, v3y);
                hold_valid <= 1'b0;
            end
            // A new candidate pushes the previously held one out; only the drain marks last.
            if (load) begin
                if (hold_valid) begin
                    pix_valid  <= 1'b1;
                    pix_x      <= hold_x;
                    pix_y      <= hold_y;
                    pix_inside <= hold_inside;
                    pix_last   <= 1'b0;
                end
                hold_valid  <= 1'b1;
                hold_x      <= x;
                hold_y      <= y;
                hold_inside <= covered;
            end
            if (advance) begin
                if (x == xmax) begin
                    x <= xmin;
                    if (!scan_end) y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (state == DRAIN && hold_valid && out_free) begin
                pix_valid  <= 1'b1;
                pix_x      <= hold_x;
                pix_y      <= hold_y;
                pix_inside <= hold_inside;
                pix_last   <= 1'b1;
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tri_raster.sv
// Self-checking bench for tri_raster: three configurations driven by directed
// and random triangles, compared against a nested-loop coverage model.
module tb_tri_raster;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [2:0]        tv, pr, tr, pv, pin, pl, bz, dn;
    logic [10:0]       p1x, p1y, p2x, p2y, p3x, p3y;
    logic [2:0][10:0]  ox, oy;
    logic [3:0]        ox2, oy2;

    int checks   = 0;
    int failures = 0;

    int rx[$];
    int ry[$];
    bit rin[$];
    bit rl[$];

    assign ox[2] = {7'd0, ox2};
    assign oy[2] = {7'd0, oy2};

    tri_raster #(.W(11), .INCLUSIVE(1'b0), .EMIT_ALL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tri_valid(tv[0]), .tri_ready(tr[0]),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .pix_valid(pv[0]), .pix_ready(pr[0]), .pix_x(ox[0]), .pix_y(oy[0]),
        .pix_inside(pin[0]), .pix_last(pl[0]), .busy(bz[0]), .done(dn[0]));

    tri_raster #(.W(11), .INCLUSIVE(1'b1), .EMIT_ALL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tri_valid(tv[1]), .tri_ready(tr[1]),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .pix_valid(pv[1]), .pix_ready(pr[1]), .pix_x(ox[1]), .pix_y(oy[1]),
        .pix_inside(pin[1]), .pix_last(pl[1]), .busy(bz[1]), .done(dn[1]));

    tri_raster #(.W(4), .INCLUSIVE(1'b1), .EMIT_ALL(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .tri_valid(tv[2]), .tri_ready(tr[2]),
        .p1x(p1x[3:0]), .p1y(p1y[3:0]), .p2x(p2x[3:0]), .p2y(p2y[3:0]),
        .p3x(p3x[3:0]), .p3y(p3y[3:0]),
        .pix_valid(pv[2]), .pix_ready(pr[2]), .pix_x(ox2), .pix_y(oy2),
        .pix_inside(pin[2]), .pix_last(pl[2]), .busy(bz[2]), .done(dn[2]));

    function automatic bit inc_of(input int d);
        return d != 0;
    endfunction

    function automatic bit ea_of(input int d);
        return d == 1;
    endfunction

    function automatic longint efn(input longint ax, ay, bx, by, px, py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    function automatic bit has_px(input int x, input int y);
        foreach (rx[i]) if (rx[i] == x && ry[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: always ready; 1: 5 stall cycles after first valid then toggle; 2: random
    task automatic run_tri(input int d, input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int mode, input int abort_after);
        int ex[$];
        int ey[$];
        bit ein[$];
        longint area, e1, e2, e3;
        int n, got, cycles, done_at, first_at, last_valid, gaps;
        bit cov, seen_done, seen_first, stalled;
        logic [23:0] saved;
        rx.delete(); ry.delete(); rin.delete(); rl.delete();
        area = efn(ax, ay, bx, by, cx, cy);
        if (area != 0) begin
            for (int y = 0; y < 16; y++) begin
                for (int x = 0; x < 16; x++) begin
                    if (x < ax && x < bx && x < cx) continue;
                    if (x > ax && x > bx && x > cx) continue;
                    if (y < ay && y < by && y < cy) continue;
                    if (y > ay && y > by && y > cy) continue;
                    e1 = efn(ax, ay, bx, by, x, y);
                    e2 = efn(bx, by, cx, cy, x, y);
                    e3 = efn(cx, cy, ax, ay, x, y);
                    if (inc_of(d)) cov = (e1 >= 0 && e2 >= 0 && e3 >= 0) || (e1 <= 0 && e2 <= 0 && e3 <= 0);
                    else           cov = (e1 > 0 && e2 > 0 && e3 > 0) || (e1 < 0 && e2 < 0 && e3 < 0);
                    if (cov || ea_of(d)) begin
                        ex.push_back(x); ey.push_back(y); ein.push_back(cov);
                    end
                end
            end
        end
        n = ex.size();

        for (int i = 0; i < 20 && !tr[d]; i++) begin
            @(posedge clk); #1;
        end
        chk("tri_ready_before", tr[d], 1);
        p1x = 11'(ax); p1y = 11'(ay); p2x = 11'(bx); p2y = 11'(by); p3x = 11'(cx); p3y = 11'(cy);
        tv[d] = 1'b1;
        pr[d] = 1'b1;
        @(posedge clk); #1;
        tv[d] = 1'b0;

        cycles = 1; got = 0; gaps = 0; last_valid = -1; done_at = -1; first_at = -1;
        seen_done = 0; seen_first = 0; stalled = 0;
        while (!seen_done && cycles < 3000) begin
            if (stalled) begin
                chk("stall_valid_held", pv[d], 1);
                chk("stall_data_held", {ox[d], oy[d], pin[d], pl[d]}, saved);
            end
            chk("busy_during", bz[d], 1);
            if (pv[d] && !seen_first) begin
                seen_first = 1; first_at = cycles;
            end
            case (mode)
                0:       pr[d] = 1'b1;
                1:       pr[d] = !seen_first ? 1'b1 :
                                 ((cycles - first_at) < 5) ? 1'b0 : 1'(cycles % 2);
                default: pr[d] = ($urandom_range(0, 3) != 0);
            endcase
            if (pv[d]) begin
                if (last_valid >= 0 && cycles - last_valid > 1) gaps++;
                last_valid = cycles;
            end
            if (pv[d] && pr[d]) begin
                rx.push_back(int'(ox[d])); ry.push_back(int'(oy[d]));
                rin.push_back(pin[d]); rl.push_back(pl[d]);
                if (got < n) begin
                    chk("pix_x", ox[d], ex[got]);
                    chk("pix_y", oy[d], ey[got]);
                    chk("pix_inside", pin[d], ein[got]);
                    chk("pix_last", pl[d], (got == n - 1));
                end else begin
                    chk("extra_pixel", 1, 0);
                end
                got++;
                if (abort_after > 0 && got == abort_after) begin
                    @(posedge clk); #1;
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    chk("abort_valid", pv[d], 0);
                    chk("abort_busy", bz[d], 0);
                    chk("abort_done", dn[d], 0);
                    chk("abort_ready", tr[d], 1);
                    rst_n = 1'b1;
                    pr[d] = 1'b1;
                    @(posedge clk); #1;
                    chk("abort_no_done", dn[d], 0);
                    chk("abort_ready_next", tr[d], 1);
                    chk("abort_valid_next", pv[d], 0);
                    return;
                end
            end
            stalled = pv[d] && !pr[d];
            saved = {ox[d], oy[d], pin[d], pl[d]};
            if (dn[d]) begin
                seen_done = 1; done_at = cycles;
            end
            @(posedge clk); #1;
            cycles++;
        end
        pr[d] = 1'b1;
        chk("done_seen", seen_done, 1);
        chk("pixel_count", got, n);
        if (mode == 0 && ea_of(d) && n > 0) chk("no_gaps", gaps, 0);
        if (area == 0) chk("degenerate_done_latency", done_at, 2);
        chk("done_one_cycle", dn[d], 0);
        chk("tri_ready_after", tr[d], 1);
        chk("busy_after", bz[d], 0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; tv = '0; pr = '1;
        p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", pv[d], 0);
            chk("rst_last", pl[d], 0);
            chk("rst_done", dn[d], 0);
            chk("rst_busy", bz[d], 0);
            chk("rst_xy_inside", {ox[d], oy[d], pin[d]}, 0);
            chk("rst_ready", tr[d], 1);
        end
        rst_n = 1'b1;

        run_tri(0, 0, 0, 4, 0, 0, 4, 0, 0);
        chk("s1_count", rx.size(), 3);
        chk("s1_first", {rx[0], ry[0]}, {32'd1, 32'd1});
        chk("s1_last", {rx[2], ry[2], 31'd0, rl[2]}, {32'd1, 32'd2, 32'd1});
        run_tri(0, 0, 0, 0, 4, 4, 0, 0, 0);
        chk("s1_rev_count", rx.size(), 3);
        chk("s1_rev_mid", {rx[1], ry[1]}, {32'd2, 32'd1});

        run_tri(1, 0, 0, 4, 0, 0, 4, 0, 0);
        cnt = 0;
        foreach (rin[i]) cnt += int'(rin[i]);
        chk("s2_all_count", rx.size(), 25);
        chk("s2_inside_count", cnt, 15);
        run_tri(2, 0, 0, 4, 0, 0, 4, 0, 0);
        chk("s2_inc_count", rx.size(), 15);
        chk("s2_inc_first", {rx[0], ry[0]}, 64'd0);
        chk("s2_inc_last", {rx[14], ry[14], 31'd0, rl[14]}, {32'd0, 32'd4, 32'd1});

        run_tri(0, 0, 0, 4, 0, 0, 4, 1, 0);
        chk("s3_count", rx.size(), 3);

        run_tri(0, 1, 1, 3, 3, 5, 5, 0, 0);
        run_tri(1, 1, 1, 3, 3, 5, 5, 0, 0);
        chk("s4_no_pixels", rx.size(), 0);

        run_tri(2, 15, 0, 0, 15, 15, 15, 0, 0);
        chk("s5_corner", has_px(15, 15), 1);
        chk("s5_edge", has_px(8, 7), 1);
        chk("s5_outside", has_px(7, 7), 0);
        chk("s5_count", rx.size(), 136);

        run_tri(1, 0, 0, 4, 0, 0, 4, 0, 2);
        run_tri(0, 0, 0, 4, 0, 0, 4, 0, 0);
        chk("s6_after_reset_count", rx.size(), 3);

        repeat (30) begin
            run_tri($urandom_range(0, 2),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 2), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
